// File: rtl/data_mem_if.sv
// MEM-stage <-> data memory controller bus: request fields in, result/handshake out.
interface data_mem_if;
    logic        mem_enable;
    logic        mem_write;
    logic        mem_size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        align_err;

    modport master (
        output mem_enable, mem_write, mem_size, addr, wdata,
        input  rdata, stall, done, align_err
    );

    modport slave (
        input  mem_enable, mem_write, mem_size, addr, wdata,
        output rdata, stall, done, align_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: 256-byte big-endian array, WAIT_CYCLES busy cycles
// per access, one-cycle completion pulse with registered load data.
module data_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic       clk,
    input logic       reset,
    data_mem_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StComplete} state_e;

    localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        size_q, size_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [7:0]  mem_q [256];

    logic        access;
    logic        acc_we, acc_size, acc_misaligned;
    logic [7:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic [5:0]  word_idx;
    logic        stall, done, align_err;

    // With zero wait cycles the access happens on the capture edge, so the live inputs are used.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = bus.mem_write;
            acc_size  = bus.mem_size;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
        end else begin
            acc_we    = we_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_misaligned = !acc_size && (acc_addr[1:0] != 2'b00);
        word_idx       = acc_addr[7:2];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        access    = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        align_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_enable) begin
                    stall   = 1'b1;
                    we_d    = bus.mem_write;
                    size_d  = bus.mem_size;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = WaitCnt;
                    if (WAIT_CYCLES > 0) begin
                        state_d = StBusy;
                    end else begin
                        state_d = StComplete;
                        access  = 1'b1;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StComplete;
                    access  = 1'b1;
                end
            end
            StComplete: begin
                done      = 1'b1;
                align_err = !size_q && (addr_q[1:0] != 2'b00);
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (access) begin
            if (acc_misaligned) begin
                rdata_d = 32'h0;
            end else if (!acc_we) begin
                if (acc_size) begin
                    rdata_d = {24'h0, mem_q[acc_addr]};
                end else begin
                    rdata_d = {mem_q[{word_idx, 2'd0}], mem_q[{word_idx, 2'd1}],
                               mem_q[{word_idx, 2'd2}], mem_q[{word_idx, 2'd3}]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= 8'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately not reset; a reset edge must never commit a store.
    always_ff @(posedge clk) begin
        if (access && acc_we && !acc_misaligned && !reset) begin
            if (acc_size) begin
                mem_q[acc_addr] <= acc_wdata[7:0];
            end else begin
                mem_q[{word_idx, 2'd0}] <= acc_wdata[31:24];
                mem_q[{word_idx, 2'd1}] <= acc_wdata[23:16];
                mem_q[{word_idx, 2'd2}] <= acc_wdata[15:8];
                mem_q[{word_idx, 2'd3}] <= acc_wdata[7:0];
            end
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.stall     = stall;
    assign bus.done      = done;
    assign bus.align_err = align_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (WAIT_CYCLES 2 and 0) checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    data_mem_if bus_a ();
    data_mem_if bus_b ();

    data_mem_ctrl #(.WAIT_CYCLES(2)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
    data_mem_ctrl #(.WAIT_CYCLES(0)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));

    logic        en [2];
    logic        we [2];
    logic        sz [2];
    logic [7:0]  ad [2];
    logic [31:0] wd [2];
    logic        st [2];
    logic        dn [2];
    logic        al [2];
    logic [31:0] rd [2];

    assign bus_a.mem_enable = en[0];
    assign bus_a.mem_write  = we[0];
    assign bus_a.mem_size   = sz[0];
    assign bus_a.addr       = ad[0];
    assign bus_a.wdata      = wd[0];
    assign bus_b.mem_enable = en[1];
    assign bus_b.mem_write  = we[1];
    assign bus_b.mem_size   = sz[1];
    assign bus_b.addr       = ad[1];
    assign bus_b.wdata      = wd[1];
    assign st[0] = bus_a.stall;
    assign dn[0] = bus_a.done;
    assign al[0] = bus_a.align_err;
    assign rd[0] = bus_a.rdata;
    assign st[1] = bus_b.stall;
    assign dn[1] = bus_b.done;
    assign al[1] = bus_b.align_err;
    assign rd[1] = bus_b.rdata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // age: 0 = no access in flight, 1..W = busy cycles, W+1 = completion cycle.
    int          wc [2] = '{2, 0};
    int          age [2] = '{0, 0};
    logic        m_we [2];
    logic        m_sz [2];
    logic [7:0]  m_ad [2];
    logic [31:0] m_wd [2];
    logic [31:0] m_rd [2];
    logic [7:0]  ref_mem [2][256];

    task automatic do_access(input int k);
        int a;
        a = int'(m_ad[k]);
        if (!m_sz[k] && m_ad[k][1:0] != 2'b00) begin
            m_rd[k] = 32'h0;
        end else if (m_we[k]) begin
            if (m_sz[k]) ref_mem[k][a] = m_wd[k][7:0];
            else for (int i = 0; i < 4; i++) ref_mem[k][a + i] = m_wd[k][31 - 8 * i -: 8];
        end else if (m_sz[k]) begin
            m_rd[k] = {24'h0, ref_mem[k][a]};
        end else begin
            m_rd[k] = {ref_mem[k][a], ref_mem[k][a + 1], ref_mem[k][a + 2], ref_mem[k][a + 3]};
        end
    endtask

    task automatic model_step(input int k);
        if (rst) begin
            age[k]  = 0;
            m_rd[k] = 32'h0;
        end else if (age[k] == 0) begin
            if (en[k]) begin
                m_we[k] = we[k];
                m_sz[k] = sz[k];
                m_ad[k] = ad[k];
                m_wd[k] = wd[k];
                age[k]  = 1;
                if (age[k] == wc[k] + 1) do_access(k);
            end
        end else if (age[k] == wc[k] + 1) begin
            age[k] = 0;
        end else begin
            age[k]++;
            if (age[k] == wc[k] + 1) do_access(k);
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        e_st, e_dn, e_al;
            logic [31:0] e_rd;
            if (rst) begin
                e_st = en[k];
                e_dn = 1'b0;
                e_al = 1'b0;
                e_rd = 32'h0;
            end else begin
                e_st = (age[k] == 0 && en[k]) || (age[k] >= 1 && age[k] <= wc[k]);
                e_dn = (age[k] == wc[k] + 1);
                e_al = e_dn && !m_sz[k] && (m_ad[k][1:0] != 2'b00);
                e_rd = m_rd[k];
            end
            chk($sformatf("stall[%0d]", k), 32'(st[k]), 32'(e_st));
            chk($sformatf("done[%0d]", k), 32'(dn[k]), 32'(e_dn));
            chk($sformatf("align_err[%0d]", k), 32'(al[k]), 32'(e_al));
            chk($sformatf("rdata[%0d]", k), rd[k], e_rd);
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; returns just after the edge leaving completion.
    task automatic xact(input int k, input logic w, input logic s, input logic [7:0] a,
                        input logic [31:0] d, input bit scramble, output int cyc,
                        output int stalls, output logic [31:0] r, output logic e);
        en[k] = 1'b1;
        we[k] = w;
        sz[k] = s;
        ad[k] = a;
        wd[k] = d;
        cyc    = 0;
        stalls = 0;
        r      = 'x;
        e      = 'x;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (st[k]) stalls++;
            if (dn[k]) begin
                r = rd[k];
                e = al[k];
                break;
            end
            if (scramble && cyc >= 2) begin
                we[k] = 1'($urandom);
                sz[k] = 1'($urandom);
                ad[k] = 8'($urandom);
                wd[k] = $urandom;
            end
        end
        if (cyc >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout[%0d]: got no done expected done within 40 cycles", k);
        end
        @(posedge clk);
        #1;
        en[k] = 1'b0;
    endtask

    task automatic init_mem(input int k);
        int c, s;
        logic [31:0] r;
        logic e;
        for (int i = 0; i < 64; i++) xact(k, 1'b1, 1'b0, 8'(i * 4), $urandom, 1'b0, c, s, r, e);
    endtask

    task automatic rand_run(input int k, input int n);
        int c, s, g;
        logic [31:0] r;
        logic e;
        logic w, z;
        logic [7:0] a;
        for (int t = 0; t < n; t++) begin
            g = int'($urandom_range(0, 2));
            repeat (g) begin
                @(posedge clk);
                #1;
                we[k] = 1'($urandom);
                sz[k] = 1'($urandom);
                ad[k] = 8'($urandom);
                wd[k] = $urandom;
            end
            w = 1'($urandom);
            z = 1'($urandom);
            a = 8'($urandom);
            if (!z && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            xact(k, w, z, a, $urandom, 1'b1, c, s, r, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, stl;
        logic [31:0] r;
        logic e;
        logic [3:0] pat_st, pat_dn;

        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0;
            we[k] = 1'b0;
            sz[k] = 1'b0;
            ad[k] = 8'h0;
            wd[k] = 32'h0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("reset_rdata", rd[0], 32'h0);
        chk("reset_stall", 32'(st[0]), 32'h0);
        chk("reset_done", 32'(dn[0]), 32'h0);
        chk("reset_align", 32'(al[0]), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        fork
            init_mem(0);
            init_mem(1);
        join

        // Directed sequence on the WAIT_CYCLES=2 instance
        xact(0, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, cyc, stl, r, e);
        chk("store_stall_cycles", 32'(stl), 32'd3);
        chk("store_done_cycle", 32'(cyc), 32'd4);
        chk("mem10", 32'(dut_a.mem_q[8'h10]), 32'hDE);
        chk("mem11", 32'(dut_a.mem_q[8'h11]), 32'hAD);
        chk("mem12", 32'(dut_a.mem_q[8'h12]), 32'hBE);
        chk("mem13", 32'(dut_a.mem_q[8'h13]), 32'hEF);
        xact(0, 1'b0, 1'b0, 8'h10, 32'h0, 1'b0, cyc, stl, r, e);
        chk("word_load10", r, 32'hDEADBEEF);
        chk("word_load10_align", 32'(e), 32'h0);
        xact(0, 1'b0, 1'b1, 8'h11, 32'h0, 1'b0, cyc, stl, r, e);
        chk("byte_load11", r, 32'h000000AD);
        xact(0, 1'b1, 1'b1, 8'h12, 32'hAAAAAA55, 1'b0, cyc, stl, r, e);
        chk("byte_store_keeps_rdata", r, 32'h000000AD);
        xact(0, 1'b0, 1'b0, 8'h10, 32'h0, 1'b0, cyc, stl, r, e);
        chk("word_load_after_byte_store", r, 32'hDEAD55EF);
        xact(0, 1'b0, 1'b0, 8'h13, 32'h0, 1'b0, cyc, stl, r, e);
        chk("misaligned_rdata", r, 32'h0);
        chk("misaligned_align_err", 32'(e), 32'h1);
        chk("misaligned_mem_unchanged", 32'(dut_a.mem_q[8'h13]), 32'hEF);
        xact(0, 1'b1, 1'b0, 8'hFC, 32'h01020304, 1'b0, cyc, stl, r, e);
        xact(0, 1'b0, 1'b0, 8'hFC, 32'h0, 1'b0, cyc, stl, r, e);
        chk("top_word_load", r, 32'h01020304);
        xact(0, 1'b1, 1'b0, 8'h20, 32'hCAFEF00D, 1'b0, cyc, stl, r, e);

        // Store aborted by reset in its second busy cycle
        en[0] = 1'b1;
        we[0] = 1'b1;
        sz[0] = 1'b0;
        ad[0] = 8'h20;
        wd[0] = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        en[0] = 1'b0;
        @(negedge clk);
        chk("abort_stall", 32'(st[0]), 32'h0);
        chk("abort_done", 32'(dn[0]), 32'h0);
        chk("abort_rdata", rd[0], 32'h0);
        chk("abort_align", 32'(al[0]), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", 32'(dn[0]), 32'h0);
        end
        chk("abort_mem20", 32'(dut_a.mem_q[8'h20]), 32'hCA);
        chk("abort_mem23", 32'(dut_a.mem_q[8'h23]), 32'h0D);
        @(posedge clk);
        #1;
        xact(0, 1'b0, 1'b0, 8'h20, 32'h0, 1'b0, cyc, stl, r, e);
        chk("load_after_abort", r, 32'hCAFEF00D);

        // WAIT_CYCLES=0 with the request held for four cycles
        pat_st = 4'b0101;
        pat_dn = 4'b1010;
        en[1] = 1'b1;
        we[1] = 1'b0;
        sz[1] = 1'b1;
        ad[1] = 8'h05;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("w0_stall_c%0d", i), 32'(st[1]), 32'(pat_st[i]));
            chk($sformatf("w0_done_c%0d", i), 32'(dn[1]), 32'(pat_dn[i]));
        end
        @(posedge clk);
        #1;
        en[1] = 1'b0;

        fork
            rand_run(0, 150);
            rand_run(1, 150);
        join

        repeat (2) @(posedge clk);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("final_mem_a[%0d]", i), 32'(dut_a.mem_q[i]), 32'(ref_mem[0][i]));
            chk($sformatf("final_mem_b[%0d]", i), 32'(dut_b.mem_q[i]), 32'(ref_mem[1][i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of BUSY cycles inserted per access (legal 0..15).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_enable  input  1  memory request from MEM stage; 1 = access requested this cycle.
REQ-005 mem_write  input  1  1 = store, 0 = load.
REQ-006 mem_size  input  1  1 = byte access, 0 = word (32-bit) access.
REQ-007 addr  input  8  byte address into a 256-byte data array.
REQ-008 wdata  input  32  store data; byte stores use wdata[7:0].
REQ-009 rdata  output  32  load result, registered.
REQ-010 stall  output  1  1 = pipeline must hold PC, IF/ID, ID/EX, EX/MEM this cycle.
REQ-011 done  output  1  one-cycle pulse: access completed, rdata/align_err valid.
REQ-012 align_err  output  1  word access with addr[1:0] != 0, valid while done = 1.

Function
REQ-013 Storage: 256 x 8-bit array, big-endian; word at a = {M[a], M[a+1], M[a+2], M[a+3]}.
REQ-014 FSM states: IDLE, BUSY, COMPLETE.
REQ-015 IDLE with mem_enable = 1: capture addr, wdata, mem_write, mem_size; load counter with WAIT_CYCLES; next = BUSY if WAIT_CYCLES > 0, else COMPLETE.
REQ-016 IDLE with mem_enable = 0: remain IDLE; stall = 0, done = 0.
REQ-017 BUSY: counter decrements each cycle; when counter = 1, next = COMPLETE; request inputs ignored (captured copy used).
REQ-018 Access is performed on the edge entering COMPLETE, using captured request only.
REQ-019 stall = 1 combinationally in IDLE when mem_enable = 1, and in every BUSY cycle; stall = 0 in COMPLETE.
REQ-020 COMPLETE lasts exactly one cycle; done = 1; next = IDLE unconditionally; mem_enable ignored in COMPLETE (same request still held by EX/MEM).
REQ-021 Latency: request first seen in IDLE -> done asserted WAIT_CYCLES + 1 cycles later; back-to-back requests separated by one IDLE cycle minimum.
REQ-022 Byte load: rdata = {24'b0, M[addr]}; byte store: M[addr] = wdata[7:0], other bytes unchanged.
REQ-023 Word load (aligned): rdata = big-endian word at addr; word store writes all four bytes.
REQ-024 Word access with addr[1:0] != 0: no array write, rdata = 0, align_err = 1 during COMPLETE.
REQ-025 Store: rdata unchanged from previous value.
REQ-026 Address wrap: aligned word at 0xFC uses bytes 0xFC..0xFF; no wrap past 0xFF occurs.
REQ-027 rdata holds its value between completions; done and align_err are 0 outside COMPLETE.

Reset
REQ-028 On reset: state = IDLE, counter = 0, rdata = 0, done = 0, align_err = 0, stall = 0 (unless mem_enable = 1 after release).
REQ-029 Reset during BUSY aborts the access: no array write, no done pulse.
REQ-030 Array contents are not cleared by reset; a test may preload them via hierarchical access.

Verification
REQ-031 WAIT_CYCLES=2, word store 0xDEADBEEF @0x10 -> stall=1 for 3 cycles, done pulse on 4th, M[0x10..0x13]=DE,AD,BE,EF.
REQ-032 Then word load @0x10 -> rdata=0xDEADBEEF with done; byte load @0x11 -> rdata=0x000000AD.
REQ-033 Byte store 0x55 @0x12 then word load @0x10 -> rdata=0xDEAD55EF.
REQ-034 Word load @0x13 -> align_err=1, rdata=0 on done; memory unchanged.
REQ-035 Word store 0x12345678 @0x20, reset asserted in 2nd BUSY cycle -> no done, M[0x20..0x23] unchanged, outputs 0.
REQ-036 WAIT_CYCLES=0, mem_enable held high for 4 cycles -> stall/done alternate 1/0, 0/1, two accesses complete.
